// File: rtl/projectile_pool.sv
// Multi-slot player projectile pool: edge-detected fire, cooldown,
// per-slot collision clearing and tick-gated upward motion.
module projectile_pool #(
  parameter int NUM_PROJ = 4,
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int SPAWN_Y  = 448,
  parameter int SPEED    = 4,
  parameter int TOP_Y    = 0,
  parameter int X_OFFSET = 30,
  parameter int X_MAX    = 639,
  parameter int COOLDOWN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         shoot,
  input  logic [X_W-1:0]               playerx,
  input  logic [NUM_PROJ-1:0]          hit,
  output logic [NUM_PROJ*X_W-1:0]      projx,
  output logic [NUM_PROJ*Y_W-1:0]      projy,
  output logic [NUM_PROJ-1:0]          exists,
  output logic                         fire_ack,
  output logic                         cooldown_busy,
  output logic [$clog2(NUM_PROJ+1)-1:0] active_count
);

  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int NW = $clog2(NUM_PROJ + 1);

  localparam logic [Y_W:0]   RET_Y   = (Y_W+1)'(TOP_Y + SPEED);
  localparam logic [X_W:0]   X_LIM   = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]   X_ADD   = (X_W+1)'(X_OFFSET);
  localparam logic [CW-1:0]  CD_LOAD = CW'(COOLDOWN);
  localparam logic [Y_W-1:0] SPD     = Y_W'(SPEED);
  localparam logic [Y_W-1:0] SY      = Y_W'(SPAWN_Y);

  logic                shoot_d;
  logic                pending;
  logic                shoot_rise;
  logic                fire;
  logic [CW-1:0]       cool;
  logic [NUM_PROJ-1:0] tgt;
  logic [X_W:0]        sum_x;
  logic [X_W-1:0]      spawn_x;
  logic [X_W-1:0]      px [NUM_PROJ];
  logic [Y_W-1:0]      py [NUM_PROJ];

  assign shoot_rise    = shoot & ~shoot_d;
  assign cooldown_busy = (cool != '0);
  assign fire = tick & (pending | shoot_rise)
              & ~cooldown_busy & ~(&exists);

  // lowest clear bit of exists, as a one-hot
  assign tgt = ~exists & (exists + NUM_PROJ'(1));

  assign sum_x   = {1'b0, playerx} + X_ADD;
  assign spawn_x = (sum_x > X_LIM) ? X_LIM[X_W-1:0]
                                   : sum_x[X_W-1:0];

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_PROJ; i++)
      active_count = active_count + NW'(exists[i]);
  end

  for (genvar g = 0; g < NUM_PROJ; g++) begin : g_pack
    assign projx[g*X_W +: X_W] = px[g];
    assign projy[g*Y_W +: Y_W] = py[g];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shoot_d  <= 1'b0;
      pending  <= 1'b0;
      cool     <= '0;
      fire_ack <= 1'b0;
    end else begin
      shoot_d  <= shoot;
      pending  <= tick ? 1'b0 : (pending | shoot_rise);
      fire_ack <= fire;
      if (fire)
        cool <= CD_LOAD;
      else if (tick && cooldown_busy)
        cool <= cool - CW'(1);
    end
  end

  // hit beats motion; spawn only targets slots empty before this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exists <= '0;
      for (int i = 0; i < NUM_PROJ; i++) begin
        px[i] <= '0;
        py[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PROJ; i++) begin
        if (hit[i] && exists[i]) begin
          exists[i] <= 1'b0;
          px[i]     <= '0;
          py[i]     <= '0;
        end else if (tick && exists[i]) begin
          if ({1'b0, py[i]} < RET_Y) begin
            exists[i] <= 1'b0;
            px[i]     <= '0;
            py[i]     <= '0;
          end else begin
            py[i] <= py[i] - SPD;
          end
        end else if (fire && tgt[i]) begin
          exists[i] <= 1'b1;
          px[i]     <= spawn_x;
          py[i]     <= SY;
        end
      end
    end
  end

endmodule

// File: tb/tb_projectile_pool.sv
// Scoreboard bench for projectile_pool: expected spawns are queued at
// stimulus time and checked by a monitor on every fire_ack pulse.
module tb_projectile_pool;

  localparam int NP = 4;
  localparam int XW = 10;
  localparam int YW = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            tick = 1'b0;
  logic            shoot = 1'b0;
  logic [XW-1:0]   playerx = '0;
  logic [NP-1:0]   hit = '0;
  logic [NP*XW-1:0] projx;
  logic [NP*YW-1:0] projy;
  logic [NP-1:0]   exists;
  logic            fire_ack;
  logic            cooldown_busy;
  logic [2:0]      active_count;

  projectile_pool dut (
    .clk(clk), .rst(rst), .tick(tick), .shoot(shoot),
    .playerx(playerx), .hit(hit), .projx(projx), .projy(projy),
    .exists(exists), .fire_ack(fire_ack),
    .cooldown_busy(cooldown_busy), .active_count(active_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int slot;
    int x;
    int y;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input int i);
    return int'(projx[i*XW +: XW]);
  endfunction

  function automatic int sy(input int i);
    return int'(projy[i*YW +: YW]);
  endfunction

  task automatic exp_fire(input int slot, input int x);
    exp_t e;
    e.slot = slot;
    e.x = x;
    e.y = 448;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tk(input logic s);
    shoot = s;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (rst && fire_ack) begin
      if (sbq.size() == 0) begin
        chk("unexpected_fire_ack", 1, 0);
      end else begin
        m = sbq.pop_front();
        chk("fire_exists", longint'(exists[m.slot]), 1);
        chk("fire_x", sx(m.slot), m.x);
        chk("fire_y", sy(m.slot), m.y);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    #12;
    chk("rst_exists", exists, 0);
    chk("rst_projx", projx, 0);
    chk("rst_projy", projy, 0);
    chk("rst_fire_ack", fire_ack, 0);
    chk("rst_busy", cooldown_busy, 0);
    chk("rst_count", active_count, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // single shot, spawn on the following tick
    playerx = 10'd100;
    shoot = 1'b1;
    cyc();
    shoot = 1'b0;
    exp_fire(0, 130);
    tk(1'b0);
    chk("p1_fire_ack", fire_ack, 1);
    chk("p1_count", active_count, 1);
    chk("p1_busy", cooldown_busy, 1);
    cyc();
    chk("p1_ack_pulse", fire_ack, 0);
    for (int k = 0; k < 112; k++) tk(1'b0);
    chk("p1_y_zero", sy(0), 0);
    chk("p1_alive_at_zero", exists[0], 1);
    tk(1'b0);
    chk("p1_retired", exists[0], 0);
    chk("p1_ret_x", sx(0), 0);
    chk("p1_ret_y", sy(0), 0);

    // held button: exactly one spawn over 20 ticks
    playerx = 10'd200;
    exp_fire(0, 230);
    for (int k = 0; k < 20; k++) tk(1'b1);
    chk("hold_count", active_count, 1);
    chk("hold_y", sy(0), 448 - 4 * 19);

    // cooldown: rise at tick 3 dropped, rise at tick 9 accepted
    tk(1'b0);
    playerx = 10'd50;
    exp_fire(1, 80);
    tk(1'b1);
    tk(1'b0);
    tk(1'b0);
    chk("cd_busy_t3", cooldown_busy, 1);
    tk(1'b1);
    chk("cd_drop_count", active_count, 2);
    for (int k = 0; k < 5; k++) tk(1'b0);
    chk("cd_idle_t9", cooldown_busy, 0);
    playerx = 10'd300;
    exp_fire(2, 330);
    tk(1'b1);
    chk("cd_t9_count", active_count, 3);
    for (int k = 0; k < 8; k++) tk(1'b0);
    playerx = 10'd0;
    exp_fire(3, 30);
    tk(1'b1);
    chk("full_count", active_count, 4);

    // pool full: request dropped
    for (int k = 0; k < 8; k++) tk(1'b0);
    chk("full_cd_idle", cooldown_busy, 0);
    tk(1'b1);
    chk("full_drop_count", active_count, 4);
    chk("full_drop_ack", fire_ack, 0);

    // hit clears slot 2 without a tick
    shoot = 1'b0;
    hit = 4'b0100;
    cyc();
    hit = '0;
    chk("hit_exists", exists, 4'b1011);
    chk("hit_x", sx(2), 0);
    chk("hit_y", sy(2), 0);
    chk("hit_count", active_count, 3);

    // refill slot 2 with saturated x
    playerx = 10'd630;
    exp_fire(2, 639);
    tk(1'b1);
    chk("sat_count", active_count, 4);
    chk("slot1_y", sy(1), 336);

    // fly slot 1 to y=200, then async reset mid-flight
    for (int k = 0; k < 34; k++) tk(1'b0);
    chk("mid_y200", sy(1), 200);
    #3 rst = 1'b0;
    #1;
    chk("arst_exists", exists, 0);
    chk("arst_projx", projx, 0);
    chk("arst_projy", projy, 0);
    chk("arst_busy", cooldown_busy, 0);
    chk("arst_count", active_count, 0);
    shoot = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    playerx = 10'd100;
    exp_fire(0, 130);
    tk(1'b1);
    chk("post_rst_ack", fire_ack, 1);
    for (int k = 0; k < 12; k++) tk(1'b1);
    chk("post_rst_count", active_count, 1);

    cyc();
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
